// File: rtl/char_buffer.sv
// Character-cell frame store with glyph rendering for the VGA driver.
// Holds H_CHARS x V_CHARS {code, colour} cells; a clear engine fills the screen after reset.
module char_buffer #(
  parameter int unsigned H_CHARS     = 80,
  parameter int unsigned V_CHARS     = 60,
  parameter logic [11:0] BG_COLOR    = 12'h000,
  parameter logic [6:0]  CLEAR_CHAR  = 7'h20,
  parameter logic [11:0] CLEAR_COLOR = 12'hFFF
) (
  input  logic        clk_25M,
  input  logic        rst_n,
  input  logic [6:0]  read_hchar,
  input  logic [5:0]  read_vchar,
  input  logic [2:0]  read_hoffset,
  input  logic [2:0]  read_voffset,
  output logic [3:0]  pixel_red,
  output logic [3:0]  pixel_green,
  output logic [3:0]  pixel_blue,
  output logic [9:0]  font_addr,
  input  logic [7:0]  font_row,
  input  logic        write_val,
  output logic        write_rdy,
  input  logic [6:0]  write_hchar,
  input  logic [5:0]  write_vchar,
  input  logic [6:0]  write_char,
  input  logic [11:0] write_color,
  input  logic        clear_req,
  output logic        clear_busy
);

  localparam int unsigned Depth = H_CHARS * V_CHARS;
  localparam int unsigned AddrW = $clog2(Depth);
  localparam logic [6:0]       HLimit   = 7'(H_CHARS);
  localparam logic [5:0]       VLimit   = 6'(V_CHARS);
  localparam logic [AddrW-1:0] LastAddr = AddrW'(Depth - 1);

  typedef enum logic [0:0] {StClear, StIdle} state_e;

  state_e             state_q, state_d;
  logic [AddrW-1:0]   cnt_q, cnt_d;

  logic [18:0]        mem_q [Depth];
  logic               mem_we;
  logic [AddrW-1:0]   mem_waddr;
  logic [18:0]        mem_wdata;

  logic               rd_in_range, wr_in_range;
  logic [AddrW-1:0]   rd_addr, wr_addr;

  logic [18:0]        rd_word_q;
  logic               in_range_q;
  logic [2:0]         hoff_q, voff_q;
  logic               glyph_bit;

  // Out-of-range coordinates are steered to address 0 so the RAM index stays legal.
  always_comb begin
    rd_in_range = (read_hchar < HLimit) && (read_vchar < VLimit);
    wr_in_range = (write_hchar < HLimit) && (write_vchar < VLimit);
    rd_addr     = '0;
    wr_addr     = '0;
    if (rd_in_range) begin
      rd_addr = AddrW'(read_vchar) * AddrW'(H_CHARS) + AddrW'(read_hchar);
    end
    if (wr_in_range) begin
      wr_addr = AddrW'(write_vchar) * AddrW'(H_CHARS) + AddrW'(write_hchar);
    end
  end

  // State register
  always_ff @(posedge clk_25M) begin
    if (!rst_n) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StClear: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastAddr) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (clear_req) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      default: state_d = StClear;
    endcase
  end

  // Output logic; RAM writes are suppressed while reset is held.
  always_comb begin
    write_rdy  = 1'b0;
    clear_busy = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = wr_addr;
    mem_wdata  = {write_char, write_color};
    unique case (state_q)
      StClear: begin
        clear_busy = 1'b1;
        mem_we     = rst_n;
        mem_waddr  = cnt_q;
        mem_wdata  = {CLEAR_CHAR, CLEAR_COLOR};
      end
      StIdle: begin
        write_rdy = 1'b1;
        mem_we    = rst_n && write_val && wr_in_range;
      end
      default: ;
    endcase
  end

  // Synchronous-read RAM; nonblocking update gives read-first on collisions.
  always_ff @(posedge clk_25M) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
    rd_word_q <= mem_q[rd_addr];
    hoff_q    <= read_hoffset;
    voff_q    <= read_voffset;
  end

  always_ff @(posedge clk_25M) begin
    if (!rst_n) begin
      in_range_q <= 1'b0;
    end else begin
      in_range_q <= rd_in_range;
    end
  end

  assign font_addr = {rd_word_q[18:12], voff_q};
  assign glyph_bit = font_row[3'd7 - hoff_q];
  assign {pixel_red, pixel_green, pixel_blue} =
      (in_range_q && glyph_bit) ? rd_word_q[11:0] : BG_COLOR;

endmodule

// File: tb/tb_char_buffer.sv
// Self-checking bench for char_buffer: directed vector table plus clear/reset sequences.
module tb_char_buffer;

  logic        clk_25M = 1'b0;
  logic        rst_n;
  logic [6:0]  read_hchar;
  logic [5:0]  read_vchar;
  logic [2:0]  read_hoffset, read_voffset;
  logic [3:0]  pixel_red, pixel_green, pixel_blue;
  logic [9:0]  font_addr;
  logic [7:0]  font_row;
  logic        write_val;
  logic        write_rdy;
  logic [6:0]  write_hchar;
  logic [5:0]  write_vchar;
  logic [6:0]  write_char;
  logic [11:0] write_color;
  logic        clear_req;
  logic        clear_busy;

  int n_cmp  = 0;
  int n_fail = 0;

  always #20 clk_25M = ~clk_25M;

  char_buffer dut (
    .clk_25M      (clk_25M),
    .rst_n        (rst_n),
    .read_hchar   (read_hchar),
    .read_vchar   (read_vchar),
    .read_hoffset (read_hoffset),
    .read_voffset (read_voffset),
    .pixel_red    (pixel_red),
    .pixel_green  (pixel_green),
    .pixel_blue   (pixel_blue),
    .font_addr    (font_addr),
    .font_row     (font_row),
    .write_val    (write_val),
    .write_rdy    (write_rdy),
    .write_hchar  (write_hchar),
    .write_vchar  (write_vchar),
    .write_char   (write_char),
    .write_color  (write_color),
    .clear_req    (clear_req),
    .clear_busy   (clear_busy)
  );

  // Font ROM model: space is blank, unknown codes are solid so stray codes show up.
  function automatic logic [7:0] font_lookup(input logic [6:0] code, input logic [2:0] row);
    logic [7:0] a [8];
    logic [7:0] b [8];
    logic [7:0] x [8];
    a = '{8'h18, 8'h24, 8'h42, 8'h42, 8'h7E, 8'h42, 8'h42, 8'h00};
    b = '{8'h7C, 8'h42, 8'h42, 8'h7C, 8'h42, 8'h42, 8'h7C, 8'h00};
    x = '{8'h42, 8'h24, 8'h18, 8'h18, 8'h18, 8'h24, 8'h42, 8'h00};
    case (code)
      7'h20:   return 8'h00;
      7'h41:   return a[row];
      7'h42:   return b[row];
      7'h58:   return x[row];
      default: return 8'hFF;
    endcase
  endfunction

  always_comb font_row = font_lookup(font_addr[9:3], font_addr[2:0]);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one read request and return the pixel produced one cycle later.
  task automatic read_px(input logic [6:0] h, input logic [5:0] v, input logic [2:0] ho,
                         input logic [2:0] vo, output logic [11:0] px);
    read_hchar = h; read_vchar = v; read_hoffset = ho; read_voffset = vo;
    @(posedge clk_25M); #1;
    px = {pixel_red, pixel_green, pixel_blue};
  endtask

  task automatic write_cell(input logic [6:0] h, input logic [5:0] v, input logic [6:0] c,
                            input logic [11:0] col, input string name);
    check(name, write_rdy, 1);
    write_val = 1'b1; write_hchar = h; write_vchar = v; write_char = c; write_color = col;
    @(posedge clk_25M); #1;
    write_val = 1'b0;
  endtask

  // Counts busy cycles starting at the current sample; optionally re-pulses clear_req.
  task automatic measure_busy(input int inject_at, output int n, output int rdy_bad);
    n = 0; rdy_bad = 0;
    while (clear_busy && n < 10000) begin
      n++;
      if (write_rdy) rdy_bad++;
      clear_req = (n == inject_at);
      @(posedge clk_25M); #1;
    end
    clear_req = 1'b0;
  endtask

  typedef struct {
    logic [6:0]  h;
    logic [5:0]  v;
    logic [2:0]  ho;
    logic [2:0]  vo;
    logic [11:0] exp;
  } vec_t;

  vec_t        vecs [14];
  logic [11:0] px;
  logic [7:0]  frow;
  int          n, rdy_bad, bad;

  initial begin
    vecs[0]  = '{7'd3,  6'd2,  3'd3, 3'd0, 12'hF00};
    vecs[1]  = '{7'd3,  6'd2,  3'd2, 3'd0, 12'h000};
    vecs[2]  = '{7'd3,  6'd2,  3'd1, 3'd4, 12'hF00};
    vecs[3]  = '{7'd3,  6'd2,  3'd0, 3'd4, 12'h000};
    vecs[4]  = '{7'd3,  6'd2,  3'd7, 3'd4, 12'h000};
    vecs[5]  = '{7'd3,  6'd2,  3'd6, 3'd4, 12'hF00};
    vecs[6]  = '{7'd3,  6'd2,  3'd1, 3'd2, 12'hF00};
    vecs[7]  = '{7'd3,  6'd2,  3'd3, 3'd7, 12'h000};
    vecs[8]  = '{7'd2,  6'd2,  3'd3, 3'd0, 12'h000};
    vecs[9]  = '{7'd3,  6'd3,  3'd3, 3'd0, 12'h000};
    vecs[10] = '{7'd79, 6'd59, 3'd1, 3'd0, 12'h00F};
    vecs[11] = '{7'd79, 6'd59, 3'd3, 3'd3, 12'h00F};
    vecs[12] = '{7'd79, 6'd59, 3'd0, 3'd0, 12'h000};
    vecs[13] = '{7'd80, 6'd0,  3'd3, 3'd0, 12'h000};

    rst_n = 1'b0; write_val = 1'b0; clear_req = 1'b0;
    write_hchar = '0; write_vchar = '0; write_char = '0; write_color = '0;
    read_hchar = '0; read_vchar = '0; read_hoffset = '0; read_voffset = '0;

    // Reset and initial clear
    @(posedge clk_25M); #1;
    @(posedge clk_25M); #1;
    check("reset_pixel", {pixel_red, pixel_green, pixel_blue}, 12'h000);
    check("reset_busy", clear_busy, 1);
    check("reset_rdy", write_rdy, 0);
    rst_n = 1'b1;
    measure_busy(0, n, rdy_bad);
    check("init_clear_len", n, 4800);
    check("init_clear_rdy_low", rdy_bad, 0);
    check("init_clear_rdy_after", write_rdy, 1);

    bad = 0;
    for (int v = 0; v < 60; v++) begin
      for (int h = 0; h < 80; h++) begin
        read_px(7'(h), 6'(v), 3'(h), 3'(v), px);
        if (px !== 12'h000) bad++;
      end
    end
    check("blank_sweep", bad, 0);

    // Write and read back through the vector table
    write_cell(7'd3, 6'd2, 7'h41, 12'hF00, "wr_a_rdy");
    write_cell(7'd79, 6'd59, 7'h58, 12'h00F, "wr_x_corner_rdy");
    foreach (vecs[i]) begin
      read_px(vecs[i].h, vecs[i].v, vecs[i].ho, vecs[i].vo, px);
      check($sformatf("vec%0d", i), px, vecs[i].exp);
    end

    bad = 0;
    for (int vo = 0; vo < 8; vo++) begin
      frow = font_lookup(7'h41, 3'(vo));
      for (int ho = 0; ho < 8; ho++) begin
        read_px(7'd3, 6'd2, 3'(ho), 3'(vo), px);
        if (px !== (frow[7 - ho] ? 12'hF00 : 12'h000)) bad++;
      end
    end
    check("glyph_a_sweep", bad, 0);

    // Out-of-range writes are accepted and dropped
    write_cell(7'd80, 6'd0, 7'h41, 12'hF00, "oor_h_rdy");
    check("oor_h_rdy_after", write_rdy, 1);
    write_cell(7'd5, 6'd60, 7'h41, 12'hF00, "oor_v_rdy");
    check("oor_v_rdy_after", write_rdy, 1);
    read_px(7'd80, 6'd0, 3'd3, 3'd0, px);
    check("oor_read_80_0", px, 12'h000);
    read_px(7'd0, 6'd1, 3'd3, 3'd0, px);
    check("oor_no_alias_0_1", px, 12'h000);
    read_px(7'd5, 6'd59, 3'd3, 3'd0, px);
    check("oor_no_alias_5_59", px, 12'h000);

    // Read/write collision returns old data, then new data
    write_val = 1'b1; write_hchar = 7'd5; write_vchar = 6'd5;
    write_char = 7'h42; write_color = 12'h0F0;
    read_px(7'd5, 6'd5, 3'd1, 3'd0, px);
    write_val = 1'b0;
    check("collide_old", px, 12'h000);
    read_px(7'd5, 6'd5, 3'd1, 3'd0, px);
    check("collide_new", px, 12'h0F0);

    // Clear request with a concurrent write; a second request mid-clear is ignored
    write_cell(7'd0, 6'd0, 7'h58, 12'h0FF, "wr_x_origin_rdy");
    read_px(7'd0, 6'd0, 3'd1, 3'd0, px);
    check("x_origin", px, 12'h0FF);
    check("clr_req_rdy", write_rdy, 1);
    clear_req = 1'b1;
    write_val = 1'b1; write_hchar = 7'd10; write_vchar = 6'd10;
    write_char = 7'h41; write_color = 12'hF00;
    @(posedge clk_25M); #1;
    clear_req = 1'b0; write_val = 1'b0;
    measure_busy(100, n, rdy_bad);
    check("req_clear_len", n, 4800);
    check("req_clear_rdy_low", rdy_bad, 0);
    read_px(7'd0, 6'd0, 3'd1, 3'd0, px);
    check("cleared_origin", px, 12'h000);
    read_px(7'd10, 6'd10, 3'd3, 3'd0, px);
    check("cleared_concurrent_wr", px, 12'h000);
    read_px(7'd3, 6'd2, 3'd3, 3'd0, px);
    check("cleared_a", px, 12'h000);

    // Reset part-way through a clear restarts it from address 0
    clear_req = 1'b1;
    @(posedge clk_25M); #1;
    clear_req = 1'b0;
    repeat (2000) begin
      @(posedge clk_25M); #1;
    end
    check("mid_clear_busy", clear_busy, 1);
    rst_n = 1'b0;
    @(posedge clk_25M); #1;
    @(posedge clk_25M); #1;
    rst_n = 1'b1;
    measure_busy(0, n, rdy_bad);
    check("rst_mid_clear_len", n, 4800);
    check("rst_mid_clear_rdy_after", write_rdy, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
